multicycle_maindec: RTL and testbench
=====================================

# multicycle_maindec

Parametrised multicycle control FSM for the 32-bit MIPS CPU; successor to the single-cycle main decoder. It supports the same instruction set (R-type, JR, LW, SW, BEQ, ADDI, J, JAL), but sequences each instruction over 3–5 states. Memory accesses use a request/ready handshake with a bounded-wait watchdog. The block sits between the instruction register and the multicycle datapath. It pairs with the existing ALU decoder through `aluop`.

## Interface
- `MAX_WAIT`, 15: maximum wait cycles tolerated on one memory access; must be ≥1.
- `SW_W`, 4: state register width (debug output width).
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `op` input 6: instruction opcode, taken from the instruction register.
- `funct` input 6: function field, taken from the instruction register.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory has completed the current request.
- `mem_req` output 1: memory request.
- `iord` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `memwrite` output 1: memory write.
- `irwrite` output 1: instruction register load.
- `regdst`, `memtoreg`, `regwrite` output 1 each: register file controls.
- `alusrca` output 1: ALU operand A select.
- `alusrcb` output 2: ALU operand B select.
- `aluop` output 2: ALU operation, passed to the ALU decoder.
- `pcsrc` output 2: PC source; 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = register.
- `pcen` output 1: PC enable.
- `jr`, `jal` output 1 each: jump-register and jump-and-link controls.
- `instret` output 1: one-cycle pulse when an instruction retires.
- `halted`, `illegal`, `memerr` output 1 each: sticky status flags.
- `state` output `SW_W`: current state, for debug.

## Operation
- States and encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - RTEXEC = 6, RTWB = 7, BEQEX = 8, ADDIEX = 9, ADDIWB = 10
  - JEX = 11, JREX = 12, JALEX = 13, HALT = 15
- Controls asserted per state are listed below. Every control not listed is 0.
- FETCH: `mem_req`=1, `alusrcb`=01. When `mem_ready`=1 in the same cycle: `irwrite`=1 and `pcen`=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE: `alusrcb`=11. Next state by opcode:
  - LW/SW → MEMADR
  - op 0 with funct 001000 → JREX; any other op 0 → RTEXEC
  - BEQ → BEQEX, ADDI → ADDIEX, J → JEX, JAL → JALEX
  - any other opcode → illegal (see Configuration)
- MEMADR: `alusrca`=1, `alusrcb`=10. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: `mem_req`=1, `iord`=1. Go to MEMWB on `mem_ready`.
- MEMWB: `regwrite`=1, `memtoreg`=1.
- MEMWR: `mem_req`=1, `iord`=1, `memwrite`=1, all held until `mem_ready`.
- RTEXEC: `alusrca`=1, `aluop`=10.
- RTWB: `regdst`=1, `regwrite`=1.
- BEQEX: `alusrca`=1, `aluop`=01, `pcsrc`=01, `pcen`=`zero`.
- ADDIEX: `alusrca`=1, `alusrcb`=10.
- ADDIWB: `regwrite`=1.
- JEX: `pcsrc`=10, `pcen`=1.
- JREX: `pcsrc`=11, `pcen`=1, `jr`=1.
- JALEX: `pcsrc`=10, `pcen`=1, `jal`=1, `regwrite`=1. The datapath writes PC+4 to $31.
- Retirement: terminal states are MEMWB, MEMWR (on `mem_ready`), RTWB, BEQEX, ADDIWB, JEX, JREX and JALEX. Each asserts `instret` for that cycle and returns to FETCH.
- Watchdog:
  - The wait counter (`$clog2(MAX_WAIT+1)` bits) clears on entry to FETCH, MEMRD or MEMWR.
  - It increments each cycle that `mem_ready`=0.
  - If `mem_ready`=0 while the count equals `MAX_WAIT`, the FSM goes to HALT and sets `memerr`.
- HALT: all controls 0 and `halted`=1. HALT is left only by reset.

## Timing
- Cycle count per instruction with zero memory wait:
  - LW 5, SW 4, R-type 4, ADDI 4
  - BEQ 3, J 3, JR 3, JAL 3
- Each memory wait cycle adds 1 to the count.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR; it is ignored in all other states.
- A memory access may last at most `MAX_WAIT`+1 cycles. `mem_ready` arriving on the final allowed cycle completes the access normally.
- Reset asserted:
  - state = FETCH; counter, `halted`, `illegal` and `memerr` all 0.
  - All outputs forced to 0 while `reset`=0, including `mem_req`.
  - Reset mid-instruction abandons that instruction with no `instret` pulse.
- First `mem_req` is asserted in the first cycle after `reset` deasserts.
- Control outputs are combinational from state, plus `mem_ready` and `zero` where listed; no output adds a register stage.

## Configuration
- `MCDEC_TRAP_EN` defined: an illegal opcode in DECODE → HALT, with `illegal`=1 and `halted`=1.
- `MCDEC_TRAP_EN` undefined: an illegal opcode is executed as a NOP. DECODE asserts `instret` and returns to FETCH, and `illegal` is tied to 0.
- The watchdog is present in both builds.

## Test plan
- Reset release with `mem_ready`=1 and an LW in the instruction register → states 0,1,2,3,4,0. `instret` pulses in state 4, and `irwrite` and `pcen` are 1 in cycle 0.
- BEQ with `zero`=1, then BEQ with `zero`=0 → `pcen`=1 in BEQEX for the first and 0 for the second. Each BEQ takes 3 cycles.
- SW with `mem_ready` low for 3 cycles in MEMWR → `memwrite` and `mem_req` held for 4 cycles. `instret` pulses on the ready cycle, then FETCH.
- `MAX_WAIT`=2 with `mem_ready` stuck at 0 in FETCH → HALT after 3 cycles with `memerr`=1 and `halted`=1. Asserting reset clears all three flags.
- op=6'b111111 → with `MCDEC_TRAP_EN`, HALT and `illegal`=1. Without it, FETCH after 2 cycles with `instret`=1.
- JAL, then funct 001000 under op 0 → JALEX (`jal`=1, `regwrite`=1), then JREX (`jr`=1, `pcsrc`=11). Asserting reset in DECODE → FETCH immediately with no `instret` pulse.

Source files
------------

// File: rtl/multicycle_maindec_if.sv
// -----------------------------------------------------------------------------
// multicycle_maindec_if
//
// Memory request/ready handshake between the multicycle control FSM and the
// unified instruction/data memory.
//
//   mem_req   : FSM -> memory, a request is outstanding this cycle
//   iord      : FSM -> memory, address select (0 = PC, 1 = ALUOut)
//   memwrite  : FSM -> memory, the outstanding request is a write
//   mem_ready : memory -> FSM, the current request completes this cycle
//
// Modports:
//   master : the control FSM side
//   slave  : the memory side
// -----------------------------------------------------------------------------
interface multicycle_maindec_if;
    logic mem_req;
    logic iord;
    logic memwrite;
    logic mem_ready;

    modport master (
        output mem_req,
        output iord,
        output memwrite,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  iord,
        input  memwrite,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_maindec.sv
// -----------------------------------------------------------------------------
// multicycle_maindec
//
// Multicycle control FSM for the 32-bit MIPS CPU. Sequences R-type, JR, LW,
// SW, BEQ, ADDI, J and JAL over 3-5 states. Memory accesses (instruction fetch,
// load, store) use a request/ready handshake guarded by a watchdog: an access
// may last at most MAX_WAIT+1 cycles, otherwise the FSM parks in HALT with
// memerr set.
//
// Parameters:
//   MAX_WAIT : maximum wait cycles tolerated on one memory access (>= 1)
//   SW_W     : state register width (>= 4, HALT is encoded as 15)
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-low reset
//   mem      : memory handshake (mem_req, iord, memwrite, mem_ready)
//   op       : instruction opcode from the instruction register
//   funct    : function field from the instruction register
//   zero     : ALU zero flag
//   irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, aluop, pcsrc,
//   pcen, jr, jal : datapath controls (combinational from state)
//   instret  : one-cycle pulse when an instruction retires
//   halted, illegal, memerr : sticky status flags, cleared only by reset
//   state    : current FSM state, for debug
//
// Build option:
//   MCDEC_TRAP_EN : when defined, an unknown opcode in DECODE traps to HALT and
//                   sets illegal. When undefined, an unknown opcode retires as
//                   a NOP straight from DECODE and illegal is tied to 0.
// -----------------------------------------------------------------------------
module multicycle_maindec #(
    parameter int MAX_WAIT = 15,
    parameter int SW_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_maindec_if.master  mem,
    input  logic [5:0]            op,
    input  logic [5:0]            funct,
    input  logic                  zero,
    output logic                  irwrite,
    output logic                  regdst,
    output logic                  memtoreg,
    output logic                  regwrite,
    output logic                  alusrca,
    output logic [1:0]            alusrcb,
    output logic [1:0]            aluop,
    output logic [1:0]            pcsrc,
    output logic                  pcen,
    output logic                  jr,
    output logic                  jal,
    output logic                  instret,
    output logic                  halted,
    output logic                  illegal,
    output logic                  memerr,
    output logic [SW_W-1:0]       state
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    // State encodings
    localparam logic [SW_W-1:0] S_FETCH  = SW_W'(0);
    localparam logic [SW_W-1:0] S_DECODE = SW_W'(1);
    localparam logic [SW_W-1:0] S_MEMADR = SW_W'(2);
    localparam logic [SW_W-1:0] S_MEMRD  = SW_W'(3);
    localparam logic [SW_W-1:0] S_MEMWB  = SW_W'(4);
    localparam logic [SW_W-1:0] S_MEMWR  = SW_W'(5);
    localparam logic [SW_W-1:0] S_RTEXEC = SW_W'(6);
    localparam logic [SW_W-1:0] S_RTWB   = SW_W'(7);
    localparam logic [SW_W-1:0] S_BEQEX  = SW_W'(8);
    localparam logic [SW_W-1:0] S_ADDIEX = SW_W'(9);
    localparam logic [SW_W-1:0] S_ADDIWB = SW_W'(10);
    localparam logic [SW_W-1:0] S_JEX    = SW_W'(11);
    localparam logic [SW_W-1:0] S_JREX   = SW_W'(12);
    localparam logic [SW_W-1:0] S_JALEX  = SW_W'(13);
    localparam logic [SW_W-1:0] S_HALT   = SW_W'(15);

    // Opcodes / function codes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // States in which mem_ready is sampled and the watchdog counts
    localparam int NUM_WAIT_STATES = 3;
    localparam logic [SW_W-1:0] WAIT_STATES [NUM_WAIT_STATES] = '{S_FETCH, S_MEMRD, S_MEMWR};

    logic [SW_W-1:0]            state_reg;
    logic [SW_W-1:0]            state_next;
    logic [CNT_W-1:0]           wait_cnt_reg;
    logic [CNT_W-1:0]           wait_cnt_next;
    logic                       halted_reg;
    logic                       memerr_reg;
    logic [NUM_WAIT_STATES-1:0] in_wait;
    logic                       mem_wait;
    logic                       wd_limit;
    logic                       wd_expire;
    logic                       op_legal;
    logic                       mem_req_c;
    logic                       iord_c;
    logic                       memwrite_c;

    // -------------------------------------------------------------------------
    // Decode helpers
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WAIT_STATES; gi++) begin : g_wait_decode
            assign in_wait[gi] = (state_reg == WAIT_STATES[gi]);
        end
    endgenerate

    assign mem_wait = |in_wait;
    assign wd_limit = (wait_cnt_reg == CNT_W'(MAX_WAIT));

    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
            OP_ADDI, OP_J, OP_JAL: op_legal = 1'b1;
            default:               op_legal = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register, watchdog counter and sticky flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            halted_reg   <= 1'b0;
            memerr_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (state_next == S_HALT) begin
                halted_reg <= 1'b1;
            end
            if (wd_expire) begin
                memerr_reg <= 1'b1;
            end
        end
    end

`ifdef MCDEC_TRAP_EN
    logic illegal_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_reg <= 1'b0;
        end else if (state_reg == S_DECODE && !op_legal) begin
            illegal_reg <= 1'b1;
        end
    end

    assign illegal = illegal_reg;
`else
    assign illegal = 1'b0;
`endif

    assign halted = halted_reg;
    assign memerr = memerr_reg;
    assign state  = state_reg;

    // -------------------------------------------------------------------------
    // Watchdog: any state change restarts the count, so it is zero on entry to
    // each wait state. It never wraps because hitting the limit leaves the
    // wait state.
    // -------------------------------------------------------------------------
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg) begin
            wait_cnt_next = '0;
        end else if (mem_wait && !mem.mem_ready) begin
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        wd_expire  = 1'b0;
        case (state_reg)
            S_FETCH: begin
                if (mem.mem_ready) begin
                    state_next = S_DECODE;
                end else if (wd_limit) begin
                    state_next = S_HALT;
                    wd_expire  = 1'b1;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = (funct == FN_JR) ? S_JREX : S_RTEXEC;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JEX;
                    OP_JAL:       state_next = S_JALEX;
`ifdef MCDEC_TRAP_EN
                    default:      state_next = S_HALT;
`else
                    default:      state_next = S_FETCH;
`endif
                endcase
            end
            // Only LW and SW reach MEMADR; the IR is stable across the sequence.
            S_MEMADR: state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD, S_MEMWR: begin
                if (mem.mem_ready) begin
                    state_next = (state_reg == S_MEMRD) ? S_MEMWB : S_FETCH;
                end else if (wd_limit) begin
                    state_next = S_HALT;
                    wd_expire  = 1'b1;
                end
            end
            S_RTEXEC: state_next = S_RTWB;
            S_ADDIEX: state_next = S_ADDIWB;
            S_MEMWB, S_RTWB, S_BEQEX, S_ADDIWB,
            S_JEX, S_JREX, S_JALEX: state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            // Unused encodings recover to FETCH.
            default:  state_next = S_FETCH;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic. Everything is held at 0 while reset is asserted, so a reset
    // mid-instruction produces no stray request or retire pulse.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_req_c  = 1'b0;
        iord_c     = 1'b0;
        memwrite_c = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        jr         = 1'b0;
        jal        = 1'b0;
        instret    = 1'b0;
        if (reset) begin
            case (state_reg)
                S_FETCH: begin
                    mem_req_c = 1'b1;
                    alusrcb   = 2'b01;
                    irwrite   = mem.mem_ready;
                    pcen      = mem.mem_ready;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
`ifdef MCDEC_TRAP_EN
                    // A trapped opcode never retires.
                    instret = 1'b0;
`else
                    // Unknown opcode retires as a NOP directly from DECODE.
                    instret = !op_legal;
`endif
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    mem_req_c = 1'b1;
                    iord_c    = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                    instret  = 1'b1;
                end
                S_MEMWR: begin
                    mem_req_c  = 1'b1;
                    iord_c     = 1'b1;
                    memwrite_c = 1'b1;
                    instret    = mem.mem_ready;
                end
                S_RTEXEC: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                S_RTWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                    instret  = 1'b1;
                end
                S_BEQEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b01;
                    pcsrc   = 2'b01;
                    pcen    = zero;
                    instret = 1'b1;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_ADDIWB: begin
                    regwrite = 1'b1;
                    instret  = 1'b1;
                end
                S_JEX: begin
                    pcsrc   = 2'b10;
                    pcen    = 1'b1;
                    instret = 1'b1;
                end
                S_JREX: begin
                    pcsrc   = 2'b11;
                    pcen    = 1'b1;
                    jr      = 1'b1;
                    instret = 1'b1;
                end
                // The datapath writes PC+4 into $31 alongside the jump.
                S_JALEX: begin
                    pcsrc    = 2'b10;
                    pcen     = 1'b1;
                    jal      = 1'b1;
                    regwrite = 1'b1;
                    instret  = 1'b1;
                end
                default: begin
                    // HALT and unused encodings drive nothing.
                    instret = 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req  = mem_req_c;
    assign mem.iord     = iord_c;
    assign mem.memwrite = memwrite_c;

endmodule

// File: tb/tb_multicycle_maindec.sv
// -----------------------------------------------------------------------------
// tb_multicycle_maindec
//
// Directed bench for multicycle_maindec. The main instance (MAX_WAIT=15) is
// driven from a per-cycle table of {op, funct, zero, mem_ready} with the
// expected state and packed control word; a second instance (MAX_WAIT=2)
// exercises the watchdog. Hand-written sequences cover reset behaviour.
// -----------------------------------------------------------------------------
module tb_multicycle_maindec;

    // Opcodes
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_NONE = 6'b000000;

    // Expected control words, field order:
    // mem_req iord memwrite irwrite regdst memtoreg regwrite alusrca
    // alusrcb[2] aluop[2] pcsrc[2] pcen jr jal instret
    localparam logic [17:0] C_ZERO       = 18'b0_0_0_0_0_0_0_0_00_00_00_0_0_0_0;
    localparam logic [17:0] C_FETCH_GO   = 18'b1_0_0_1_0_0_0_0_01_00_00_1_0_0_0;
    localparam logic [17:0] C_FETCH_WAIT = 18'b1_0_0_0_0_0_0_0_01_00_00_0_0_0_0;
    localparam logic [17:0] C_DECODE     = 18'b0_0_0_0_0_0_0_0_11_00_00_0_0_0_0;
    localparam logic [17:0] C_DECODE_NOP = 18'b0_0_0_0_0_0_0_0_11_00_00_0_0_0_1;
    localparam logic [17:0] C_MEMADR     = 18'b0_0_0_0_0_0_0_1_10_00_00_0_0_0_0;
    localparam logic [17:0] C_MEMRD      = 18'b1_1_0_0_0_0_0_0_00_00_00_0_0_0_0;
    localparam logic [17:0] C_MEMWB      = 18'b0_0_0_0_0_1_1_0_00_00_00_0_0_0_1;
    localparam logic [17:0] C_MEMWR_WAIT = 18'b1_1_1_0_0_0_0_0_00_00_00_0_0_0_0;
    localparam logic [17:0] C_MEMWR_GO   = 18'b1_1_1_0_0_0_0_0_00_00_00_0_0_0_1;
    localparam logic [17:0] C_RTEXEC     = 18'b0_0_0_0_0_0_0_1_00_10_00_0_0_0_0;
    localparam logic [17:0] C_RTWB       = 18'b0_0_0_0_1_0_1_0_00_00_00_0_0_0_1;
    localparam logic [17:0] C_BEQ_T      = 18'b0_0_0_0_0_0_0_1_00_01_01_1_0_0_1;
    localparam logic [17:0] C_BEQ_F      = 18'b0_0_0_0_0_0_0_1_00_01_01_0_0_0_1;
    localparam logic [17:0] C_ADDIEX     = 18'b0_0_0_0_0_0_0_1_10_00_00_0_0_0_0;
    localparam logic [17:0] C_ADDIWB     = 18'b0_0_0_0_0_0_1_0_00_00_00_0_0_0_1;
    localparam logic [17:0] C_JEX        = 18'b0_0_0_0_0_0_0_0_00_00_10_1_0_0_1;
    localparam logic [17:0] C_JREX       = 18'b0_0_0_0_0_0_0_0_00_00_11_1_1_0_1;
    localparam logic [17:0] C_JALEX      = 18'b0_0_0_0_0_0_1_0_00_00_10_1_0_1_1;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        ready;
        logic [3:0]  st;
        logic [17:0] ctl;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance (MAX_WAIT = 15) ----------------
    logic        reset;
    logic [5:0]  op, funct;
    logic        zero;
    logic        irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0]  alusrcb, aluop, pcsrc;
    logic        pcen, jr, jal, instret, halted, illegal, memerr;
    logic [3:0]  state;

    multicycle_maindec_if bus ();

    multicycle_maindec #(.MAX_WAIT(15), .SW_W(4)) dut (
        .clk(clk), .reset(reset), .mem(bus), .op(op), .funct(funct), .zero(zero),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
        .pcen(pcen), .jr(jr), .jal(jal), .instret(instret), .halted(halted),
        .illegal(illegal), .memerr(memerr), .state(state)
    );

    wire [17:0] ctl = {bus.mem_req, bus.iord, bus.memwrite, irwrite, regdst, memtoreg,
                       regwrite, alusrca, alusrcb, aluop, pcsrc, pcen, jr, jal, instret};

    // ---------------- watchdog instance (MAX_WAIT = 2) ----------------
    logic        reset2;
    logic [5:0]  op2, funct2;
    logic        zero2;
    logic        irwrite2, regdst2, memtoreg2, regwrite2, alusrca2;
    logic [1:0]  alusrcb2, aluop2, pcsrc2;
    logic        pcen2, jr2, jal2, instret2, halted2, illegal2, memerr2;
    logic [3:0]  state2;

    multicycle_maindec_if bus2 ();

    multicycle_maindec #(.MAX_WAIT(2), .SW_W(4)) dut2 (
        .clk(clk), .reset(reset2), .mem(bus2), .op(op2), .funct(funct2), .zero(zero2),
        .irwrite(irwrite2), .regdst(regdst2), .memtoreg(memtoreg2), .regwrite(regwrite2),
        .alusrca(alusrca2), .alusrcb(alusrcb2), .aluop(aluop2), .pcsrc(pcsrc2),
        .pcen(pcen2), .jr(jr2), .jal(jal2), .instret(instret2), .halted(halted2),
        .illegal(illegal2), .memerr(memerr2), .state(state2)
    );

    wire [17:0] ctl2 = {bus2.mem_req, bus2.iord, bus2.memwrite, irwrite2, regdst2, memtoreg2,
                        regwrite2, alusrca2, alusrcb2, aluop2, pcsrc2, pcen2, jr2, jal2, instret2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic r, input logic [3:0] s, input logic [17:0] c);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.ready = r; v.st = s; v.ctl = c;
        vecs.push_back(v);
    endtask

    initial begin
        // ---------------- vector table ----------------
        // LW, zero wait: states 0,1,2,3,4
        add(OP_LW,   FN_NONE, 0, 1, 0,  C_FETCH_GO);
        add(OP_LW,   FN_NONE, 0, 0, 1,  C_DECODE);
        add(OP_LW,   FN_NONE, 0, 0, 2,  C_MEMADR);
        add(OP_LW,   FN_NONE, 0, 1, 3,  C_MEMRD);
        add(OP_LW,   FN_NONE, 0, 0, 4,  C_MEMWB);
        // BEQ taken then not taken
        add(OP_BEQ,  FN_NONE, 1, 1, 0,  C_FETCH_GO);
        add(OP_BEQ,  FN_NONE, 1, 1, 1,  C_DECODE);
        add(OP_BEQ,  FN_NONE, 1, 0, 8,  C_BEQ_T);
        add(OP_BEQ,  FN_NONE, 0, 1, 0,  C_FETCH_GO);
        add(OP_BEQ,  FN_NONE, 0, 1, 1,  C_DECODE);
        add(OP_BEQ,  FN_NONE, 0, 1, 8,  C_BEQ_F);
        // SW with three wait cycles in MEMWR
        add(OP_SW,   FN_NONE, 0, 1, 0,  C_FETCH_GO);
        add(OP_SW,   FN_NONE, 0, 1, 1,  C_DECODE);
        add(OP_SW,   FN_NONE, 0, 1, 2,  C_MEMADR);
        add(OP_SW,   FN_NONE, 0, 0, 5,  C_MEMWR_WAIT);
        add(OP_SW,   FN_NONE, 0, 0, 5,  C_MEMWR_WAIT);
        add(OP_SW,   FN_NONE, 0, 0, 5,  C_MEMWR_WAIT);
        add(OP_SW,   FN_NONE, 0, 1, 5,  C_MEMWR_GO);
        // R-type
        add(OP_RT,   FN_ADD,  0, 1, 0,  C_FETCH_GO);
        add(OP_RT,   FN_ADD,  0, 1, 1,  C_DECODE);
        add(OP_RT,   FN_ADD,  0, 1, 6,  C_RTEXEC);
        add(OP_RT,   FN_ADD,  0, 1, 7,  C_RTWB);
        // ADDI with one fetch wait cycle
        add(OP_ADDI, FN_NONE, 0, 0, 0,  C_FETCH_WAIT);
        add(OP_ADDI, FN_NONE, 0, 1, 0,  C_FETCH_GO);
        add(OP_ADDI, FN_NONE, 0, 1, 1,  C_DECODE);
        add(OP_ADDI, FN_NONE, 0, 1, 9,  C_ADDIEX);
        add(OP_ADDI, FN_NONE, 0, 1, 10, C_ADDIWB);
        // J, JAL, JR
        add(OP_J,    FN_NONE, 0, 1, 0,  C_FETCH_GO);
        add(OP_J,    FN_NONE, 0, 1, 1,  C_DECODE);
        add(OP_J,    FN_NONE, 0, 1, 11, C_JEX);
        add(OP_JAL,  FN_NONE, 0, 1, 0,  C_FETCH_GO);
        add(OP_JAL,  FN_NONE, 0, 1, 1,  C_DECODE);
        add(OP_JAL,  FN_NONE, 0, 1, 13, C_JALEX);
        add(OP_RT,   FN_JR,   0, 1, 0,  C_FETCH_GO);
        add(OP_RT,   FN_JR,   0, 1, 1,  C_DECODE);
        add(OP_RT,   FN_JR,   0, 1, 12, C_JREX);
        // LW with one wait cycle in MEMRD
        add(OP_LW,   FN_NONE, 0, 1, 0,  C_FETCH_GO);
        add(OP_LW,   FN_NONE, 0, 1, 1,  C_DECODE);
        add(OP_LW,   FN_NONE, 0, 1, 2,  C_MEMADR);
        add(OP_LW,   FN_NONE, 0, 0, 3,  C_MEMRD);
        add(OP_LW,   FN_NONE, 0, 1, 3,  C_MEMRD);
        add(OP_LW,   FN_NONE, 0, 1, 4,  C_MEMWB);
        // Illegal opcode
        add(OP_BAD,  FN_NONE, 0, 1, 0,  C_FETCH_GO);
`ifdef MCDEC_TRAP_EN
        add(OP_BAD,  FN_NONE, 0, 1, 1,  C_DECODE);
        add(OP_BAD,  FN_NONE, 0, 0, 15, C_ZERO);
`else
        add(OP_BAD,  FN_NONE, 0, 1, 1,  C_DECODE_NOP);
        add(OP_BAD,  FN_NONE, 0, 0, 0,  C_FETCH_WAIT);
`endif

        // ---------------- reset state ----------------
        reset = 1'b0; op = OP_LW; funct = FN_NONE; zero = 1'b0; bus.mem_ready = 1'b1;
        reset2 = 1'b0; op2 = OP_LW; funct2 = FN_NONE; zero2 = 1'b0; bus2.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset state", {28'd0, state}, 32'd0);
        check("reset ctl forced 0", {14'd0, ctl}, {14'd0, C_ZERO});
        check("reset flags", {29'd0, halted, illegal, memerr}, 32'd0);
        check("reset2 ctl forced 0", {14'd0, ctl2}, {14'd0, C_ZERO});
        @(negedge clk);
        reset = 1'b1;

        // ---------------- table loop ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            op = vecs[i].op;
            funct = vecs[i].funct;
            zero = vecs[i].zero;
            bus.mem_ready = vecs[i].ready;
            #1;
            check($sformatf("vec%0d state", i), {28'd0, state}, {28'd0, vecs[i].st});
            check($sformatf("vec%0d ctl", i), {14'd0, ctl}, {14'd0, vecs[i].ctl});
            $display("vec %0d: op=%b funct=%b zero=%b ready=%b -> state=%0d ctl=%b",
                     i, op, funct, zero, bus.mem_ready, state, ctl);
            @(negedge clk);
        end

`ifdef MCDEC_TRAP_EN
        check("trap illegal flag", {31'd0, illegal}, 32'd1);
        check("trap halted flag", {31'd0, halted}, 32'd1);
`else
        check("nop illegal flag", {31'd0, illegal}, 32'd0);
        check("nop halted flag", {31'd0, halted}, 32'd0);
`endif
        check("memerr clear after table", {31'd0, memerr}, 32'd0);

        // ---------------- reset in DECODE ----------------
        reset = 1'b0;
        #1;
        check("rst flags cleared", {29'd0, halted, illegal, memerr}, 32'd0);
        check("rst state", {28'd0, state}, 32'd0);
        @(negedge clk);
        reset = 1'b1; op = OP_JAL; funct = FN_NONE; bus.mem_ready = 1'b1;
        #1;
        check("rst seq fetch ctl", {14'd0, ctl}, {14'd0, C_FETCH_GO});
        $display("rst seq: fetch state=%0d ctl=%b", state, ctl);
        @(negedge clk);
        #1;
        check("rst seq decode state", {28'd0, state}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst mid-decode state", {28'd0, state}, 32'd0);
        check("rst mid-decode ctl", {14'd0, ctl}, {14'd0, C_ZERO});
        $display("rst seq: reset in decode state=%0d instret=%b", state, instret);
        @(negedge clk);
        check("rst held instret", {31'd0, instret}, 32'd0);
        reset = 1'b1;
        #1;
        check("rst release mem_req", {31'd0, bus.mem_req}, 32'd1);
        check("rst release state", {28'd0, state}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst seq jalex", {14'd0, ctl}, {14'd0, C_JALEX});
        $display("rst seq: jal state=%0d ctl=%b", state, ctl);

        // ---------------- watchdog, MAX_WAIT = 2, stuck in FETCH ----------------
        @(negedge clk);
        reset2 = 1'b1; bus2.mem_ready = 1'b0; op2 = OP_LW;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("wd fetch cyc%0d state", c), {28'd0, state2}, 32'd0);
            check($sformatf("wd fetch cyc%0d memerr", c), {31'd0, memerr2}, 32'd0);
            $display("wd fetch: cycle %0d state=%0d ctl=%b", c, state2, ctl2);
            @(negedge clk);
        end
        #1;
        check("wd halt state", {28'd0, state2}, 32'd15);
        check("wd halt flags", {29'd0, halted2, illegal2, memerr2}, 32'b101);
        check("wd halt ctl", {14'd0, ctl2}, {14'd0, C_ZERO});
        bus2.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("wd halt sticky", {28'd0, state2}, 32'd15);
        check("wd halt ctl ready", {14'd0, ctl2}, {14'd0, C_ZERO});
        reset2 = 1'b0;
        #1;
        check("wd reset flags", {29'd0, halted2, illegal2, memerr2}, 32'd0);
        check("wd reset state", {28'd0, state2}, 32'd0);

        // ---------------- watchdog boundary: ready on last allowed cycle ----------------
        @(negedge clk);
        reset2 = 1'b1; bus2.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus2.mem_ready = 1'b1;
        #1;
        check("wd boundary fetch ctl", {14'd0, ctl2}, {14'd0, C_FETCH_GO});
        @(negedge clk);
        bus2.mem_ready = 1'b0;
        #1;
        check("wd boundary decode", {28'd0, state2}, 32'd1);
        check("wd boundary memerr", {31'd0, memerr2}, 32'd0);
        $display("wd boundary: state=%0d memerr=%b", state2, memerr2);

        // ---------------- watchdog in MEMRD ----------------
        @(negedge clk);
        #1;
        check("wd memadr", {28'd0, state2}, 32'd2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("wd memrd cyc%0d state", c), {28'd0, state2}, 32'd3);
        end
        @(negedge clk);
        #1;
        check("wd memrd halt state", {28'd0, state2}, 32'd15);
        check("wd memrd halt flags", {29'd0, halted2, illegal2, memerr2}, 32'b101);
        $display("wd memrd: state=%0d halted=%b memerr=%b", state2, halted2, memerr2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
